// File: rtl/mux_2to1.sv
// 2:1 word mux with combinational output and a registered, validated copy.
// Optional MUX_2TO1_PARITY_EN adds a registered even-parity output y_par.
module mux_2to1 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             s,
  input  logic             en,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             y_valid,
  output logic             y_chg
`ifdef MUX_2TO1_PARITY_EN
  ,
  output logic             y_par
`endif
);

  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] r_q;
  logic             r_valid;
  logic             r_chg;

  // select; an unknown select falls through to d0
  always_comb begin
    w_y = d0;
    if (s) w_y = d1;
  end

  // capture/hold register with change detect against the previous word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q     <= '0;
      r_valid <= 1'b0;
      r_chg   <= 1'b0;
    end else if (en) begin
      r_q     <= w_y;
      r_valid <= 1'b1;
      r_chg   <= (w_y != r_q) || !r_valid;
    end else begin
      r_chg   <= 1'b0;
    end
  end

`ifdef MUX_2TO1_PARITY_EN
  logic r_par;

  // parity bit travels with the captured word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_par <= 1'b0;
    end else if (en) begin
      r_par <= ^w_y;
    end
  end

  assign y_par = r_par;
`endif

  assign y       = w_y;
  assign y_q     = r_q;
  assign y_valid = r_valid;
  assign y_chg   = r_chg;

endmodule

// File: tb/tb_mux_2to1.sv
// Scoreboard bench for mux_2to1 (WIDTH=8).
// Stimulus pushes expected register state; a monitor pops after each edge.
module tb_mux_2to1;

  logic       clk;
  logic       rst_n;
  logic [7:0] d0;
  logic [7:0] d1;
  logic       s;
  logic       en;
  logic [7:0] y;
  logic [7:0] y_q;
  logic       y_valid;
  logic       y_chg;
`ifdef MUX_2TO1_PARITY_EN
  logic       y_par;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] q;
    logic       v;
    logic       chg;
    logic       par;
  } exp_t;

  exp_t sb[$];

  logic [7:0] m_q;
  logic       m_v;
  logic       m_chg;
  logic       m_par;

  mux_2to1 #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .d0      (d0),
    .d1      (d1),
    .s       (s),
    .en      (en),
    .y       (y),
    .y_q     (y_q),
    .y_valid (y_valid),
    .y_chg   (y_chg)
`ifdef MUX_2TO1_PARITY_EN
    ,
    .y_par   (y_par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk8(input string nm, input logic [7:0] act,
                      input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  // monitor: registered outputs compared 1 time unit after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk8("y_q", y_q, e.q);
        chk1("y_valid", y_valid, e.v);
        chk1("y_chg", y_chg, e.chg);
`ifdef MUX_2TO1_PARITY_EN
        chk1("y_par", y_par, e.par);
`endif
      end
    end
  end

  // one clock: drive, check comb y, push expected state, cross the edge
  task automatic cyc(input logic r, input logic e, input logic sel,
                     input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] ey, input logic [7:0] eq,
                     input logic ev, input logic ec, input logic ep);
    exp_t x;
    rst_n = r;
    en    = e;
    s     = sel;
    d0    = a;
    d1    = b;
    #1;
    chk8("y", y, ey);
    x.q   = eq;
    x.v   = ev;
    x.chg = ec;
    x.par = ep;
    sb.push_back(x);
    @(posedge clk);
    @(negedge clk);
  endtask

  // bench reference for the soak phase
  task automatic soak_cyc(input logic r, input logic e, input logic sel,
                          input logic [7:0] a, input logic [7:0] b);
    logic [7:0] ey;
    ey = sel ? b : a;
    if (!r) begin
      m_q = 8'h00; m_v = 1'b0; m_chg = 1'b0; m_par = 1'b0;
    end else if (e) begin
      m_chg = (ey != m_q) || !m_v;
      m_q   = ey;
      m_v   = 1'b1;
      m_par = ^ey;
    end else begin
      m_chg = 1'b0;
    end
    cyc(r, e, sel, a, b, ey, m_q, m_v, m_chg, m_par);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    d0    = 8'h3C;
    d1    = 8'hA5;
    s     = 1'b0;
    #1;
    chk8("comb_s0", y, 8'h3C);
    s = 1'b1;
    #1;
    chk8("comb_s1", y, 8'hA5);
    #1;
    // reset held two edges with en=1
    cyc(0, 1, 1, 8'h3C, 8'hFF, 8'hFF, 8'h00, 0, 0, 0);
    cyc(0, 1, 1, 8'h3C, 8'hFF, 8'hFF, 8'h00, 0, 0, 0);
    // first capture
    cyc(1, 1, 0, 8'h12, 8'hFF, 8'h12, 8'h12, 1, 1, 0);
    // hold with new inputs
    cyc(1, 0, 1, 8'h12, 8'h77, 8'h77, 8'h12, 1, 0, 0);
    // capture changed value, then same value again
    cyc(1, 1, 1, 8'h12, 8'h77, 8'h77, 8'h77, 1, 1, 0);
    cyc(1, 1, 1, 8'h12, 8'h77, 8'h77, 8'h77, 1, 0, 0);
    // mid-run reset with en=1
    cyc(0, 1, 1, 8'h12, 8'h77, 8'h77, 8'h00, 0, 0, 0);
    // odd-parity word after reset
    cyc(1, 1, 1, 8'h00, 8'h07, 8'h07, 8'h07, 1, 1, 1);
    // same word via the other input: no change pulse
    cyc(1, 1, 0, 8'h07, 8'h07, 8'h07, 8'h07, 1, 0, 1);
    // hold keeps word and parity
    cyc(1, 0, 0, 8'hAA, 8'h00, 8'hAA, 8'h07, 1, 0, 1);
    // zero word captured: changed, even parity
    cyc(1, 1, 0, 8'h00, 8'hFF, 8'h00, 8'h00, 1, 1, 0);

    m_q = 8'h00; m_v = 1'b1; m_chg = 1'b1; m_par = 1'b0;
    for (int i = 0; i < 200; i++) begin
      soak_cyc(($urandom_range(0, 15) != 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    end
    // parity spot check after the soak
    soak_cyc(1, 1, 1, 8'h00, 8'h07);

    repeat (2) @(posedge clk);
    #2;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d left want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
